// File: rtl/cell_bist_ctrl.sv
// cell_bist_ctrl -- built-in self-test sequencer for one standard-cell instance.
//
// Applies every input pattern 0 .. 2^NUMIN-1 to the cell under test. After
// SETTLE wait cycles it samples the cell output and compares it against the
// golden truth table for the latched function. It reports pass/fail, a
// saturating mismatch count and the first failing pattern.
//
// Parameters:
//   NIN    width of the stimulus bus / maximum cell fan-in
//   SETTLE wait cycles between applying a pattern and sampling RESP (0..15)
//   ERRW   width of the mismatch counter
//
// Ports:
//   CK        clock, rising edge
//   RST       synchronous active-high reset
//   START     start request, only looked at in IDLE
//   FUNC      cell function: 0 AND 1 NAND 2 OR 3 NOR 4 XOR 5 XNOR 6 BUF 7 INV
//   NUMIN     cell fan-in (1..4)
//   STIM      cell inputs, bit 0 drives A1/A
//   RESP      cell output
//   BUSY      sweep in progress
//   DONE      one-cycle completion pulse
//   PASS      result, valid from DONE until the next accepted START
//   CFGERR    illegal FUNC/NUMIN combination
//   ERRCNT    saturating mismatch count
//   FAILVEC   first failing pattern (0 when capture is compiled out)
//   fsm_state debug view of the FSM: 0 IDLE, 1 APPLY, 2 WAIT, 3 SAMPLE, 4 FIN
//
// Handshake: the host raises START while the block is idle. The block answers
// with BUSY for the sweep and then a single-cycle DONE. The next START is
// accepted from the cycle after DONE.
//
// Build option: define CELL_BIST_FAILVEC_EN to include first-failing-pattern
// capture. Without it FAILVEC is tied to 0.
module cell_bist_ctrl #(
  parameter int NIN    = 4,
  parameter int SETTLE = 1,
  parameter int ERRW   = 8
) (
  input  logic            CK,
  input  logic            RST,
  input  logic            START,
  input  logic [2:0]      FUNC,
  input  logic [2:0]      NUMIN,
  output logic [NIN-1:0]  STIM,
  input  logic            RESP,
  output logic            BUSY,
  output logic            DONE,
  output logic            PASS,
  output logic            CFGERR,
  output logic [ERRW-1:0] ERRCNT,
  output logic [NIN-1:0]  FAILVEC,
  output logic [2:0]      fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_WAIT   = 3'd2,
    S_SAMPLE = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  localparam bit         HAS_SETTLE  = (SETTLE > 0);
  localparam logic [3:0] SETTLE_LAST = 4'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_t         state, state_nx;
  logic [2:0]     func_q;
  logic [2:0]     numin_q;
  logic [3:0]     wait_cnt;
  logic           pass_q;
  logic           cfg_bad;
  logic [NIN-1:0] all_ones;
  logic           last_pat;
  logic           expected;
  logic           mismatch;

  // Legality of the live FUNC/NUMIN inputs, evaluated when START is accepted.
  always_comb begin
    cfg_bad = 1'b0;
    if (NUMIN == 3'd0 || NUMIN > 3'd4 || int'(NUMIN) > NIN) cfg_bad = 1'b1;
    case (FUNC)
      3'd4, 3'd5: if (NUMIN != 3'd2) cfg_bad = 1'b1;
      3'd6, 3'd7: if (NUMIN != 3'd1) cfg_bad = 1'b1;
      default:    if (NUMIN < 3'd2)  cfg_bad = 1'b1;
    endcase
  end

  // STIM doubles as the pattern counter. Patterns never exceed all_ones, so
  // the bits at index NUMIN and above stay 0 without explicit masking.
  always_comb begin
    all_ones = NIN'((32'd1 << numin_q) - 32'd1);
    last_pat = (STIM == all_ones);
    // func_q[2:1] selects the base function; func_q[0] inverts it.
    case (func_q[2:1])
      2'd0:    expected = (STIM == all_ones);
      2'd1:    expected = |STIM;
      2'd2:    expected = ^STIM;
      default: expected = STIM[0];
    endcase
    expected = expected ^ func_q[0];
    mismatch = (RESP != expected);
  end

  always_ff @(posedge CK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (START) state_nx = cfg_bad ? S_FIN : S_APPLY;
      S_APPLY:  state_nx = HAS_SETTLE ? S_WAIT : S_SAMPLE;
      S_WAIT:   if (wait_cnt == SETTLE_LAST) state_nx = S_SAMPLE;
      S_SAMPLE: state_nx = last_pat ? S_FIN : S_APPLY;
      S_FIN:    state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY      = (state == S_APPLY) || (state == S_WAIT) || (state == S_SAMPLE);
    DONE      = (state == S_FIN);
    // In FIN the counter already holds the final sample, so PASS is
    // available in the DONE cycle itself and then held in pass_q.
    PASS      = (state == S_FIN) ? ((ERRCNT == '0) && !CFGERR) : pass_q;
    fsm_state = state;
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      func_q   <= '0;
      numin_q  <= '0;
      wait_cnt <= '0;
      pass_q   <= 1'b0;
      CFGERR   <= 1'b0;
      ERRCNT   <= '0;
      STIM     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            func_q   <= FUNC;
            numin_q  <= NUMIN;
            wait_cnt <= '0;
            pass_q   <= 1'b0;
            CFGERR   <= cfg_bad;
            ERRCNT   <= '0;
            STIM     <= '0;
          end
        end
        S_APPLY: wait_cnt <= '0;
        S_WAIT:  wait_cnt <= wait_cnt + 4'd1;
        S_SAMPLE: begin
          if (mismatch && ERRCNT != {ERRW{1'b1}}) ERRCNT <= ERRCNT + 1'b1;
          if (!last_pat) STIM <= STIM + 1'b1;
        end
        S_FIN:   pass_q <= PASS;
        default: ;
      endcase
    end
  end

`ifdef CELL_BIST_FAILVEC_EN
  logic first_seen;

  always_ff @(posedge CK) begin
    if (RST) begin
      first_seen <= 1'b0;
      FAILVEC    <= '0;
    end else if (state == S_IDLE && START) begin
      first_seen <= 1'b0;
      FAILVEC    <= '0;
    end else if (state == S_SAMPLE && mismatch && !first_seen) begin
      first_seen <= 1'b1;
      FAILVEC    <= STIM;
    end
  end
`else
  assign FAILVEC = '0;
`endif

endmodule
